// File: rtl/store_byte_rmw_pkg.sv
// Shared definitions for the store-byte read-modify-write unit:
// FSM state encodings, byte-lane numbering and the lane-select helper.
package store_byte_rmw_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Lane n always means word bits [8n+7:8n], whatever the endianness.
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Byte offset within the word -> physical lane; big-endian mirrors the offset.
    function automatic logic [1:0] lane_of(input logic [1:0] offset, input logic big_endian);
        lane_of = big_endian ? ~offset : offset;
    endfunction

endpackage

// File: rtl/store_byte_rmw_byte_lane_merge.sv
// byte_lane_merge: replaces one byte lane of a 32-bit word with a new byte.
// Purely combinational; the other 24 bits pass through unchanged.
module byte_lane_merge
    import store_byte_rmw_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o
);

    // Overwrite the selected lane, keep everything else.
    always_comb begin
        merged_o = word_i;
        case (lane_i)
            LANE_0:  merged_o[7:0]   = byte_i;
            LANE_1:  merged_o[15:8]  = byte_i;
            LANE_2:  merged_o[23:16] = byte_i;
            LANE_3:  merged_o[31:24] = byte_i;
            default: merged_o        = word_i;
        endcase
    end

endmodule

// File: rtl/store_byte_rmw.sv
// store_byte_rmw: MIPS sb against a word-wide memory via read-modify-write.
// IDLE -> RD -> WR -> DONE; a new request may be taken in DONE.
// Optional macro STORE_BYTE_RMW_FWD_EN keeps the last written word so a
// store to the same word skips the read (IDLE -> WR).
module store_byte_rmw
    import store_byte_rmw_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned ADDR_W     = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sb_req,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [31:0]       sb_data,
    output logic              sb_ready,
    output logic              sb_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        byte_q, byte_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic              we_q, we_d;

    logic              accept_s;
    logic              hit_s;
    logic [ADDR_W-1:0] req_word_s;
    logic [1:0]        req_lane_s;
    logic [31:0]       mrg_word_s;
    logic [7:0]        mrg_byte_s;
    logic [1:0]        mrg_lane_s;
    logic [31:0]       merged_s;
    logic              unused_hi_s;

    // Only the low byte of the store data is meaningful.
    assign unused_hi_s = ^sb_data[31:8];
    assign req_word_s  = {sb_addr[ADDR_W-1:2], 2'b00};
    assign req_lane_s  = lane_of(sb_addr[1:0], BIG_ENDIAN);
    assign accept_s    = sb_req & ready_q;

`ifdef STORE_BYTE_RMW_FWD_EN
    logic              cache_vld_q, cache_vld_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [31:0]       cache_word_q, cache_word_d;

    assign hit_s = cache_vld_q & (cache_addr_q == req_word_s);

    // Merge source: memory read data in RD, otherwise the cached word for a hit.
    always_comb begin
        mrg_word_s = mem_rdata;
        mrg_byte_s = byte_q;
        mrg_lane_s = lane_q;
        if (state_q == ST_RD) begin
            mrg_word_s = mem_rdata;
            mrg_byte_s = byte_q;
            mrg_lane_s = lane_q;
        end else begin
            mrg_word_s = cache_word_q;
            mrg_byte_s = sb_data[7:0];
            mrg_lane_s = req_lane_s;
        end
    end

    // Every completed write becomes the cached word, replacing any older entry.
    always_comb begin
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_word_d = cache_word_q;
        if ((state_q == ST_WR) && mem_wack) begin
            cache_vld_d  = 1'b1;
            cache_addr_d = addr_q;
            cache_word_d = wdata_q;
        end else begin
            cache_vld_d  = cache_vld_q;
        end
    end

    // Cache registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld_q  <= 1'b0;
            cache_addr_q <= {ADDR_W{1'b0}};
            cache_word_q <= 32'h0000_0000;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_word_q <= cache_word_d;
        end
    end
`else
    assign hit_s = 1'b0;

    // Without the cache the merge always works on freshly read data.
    always_comb begin
        mrg_word_s = mem_rdata;
        mrg_byte_s = byte_q;
        mrg_lane_s = lane_q;
    end
`endif

    byte_lane_merge u_merge (
        .word_i   (mrg_word_s),
        .byte_i   (mrg_byte_s),
        .lane_i   (mrg_lane_s),
        .merged_o (merged_s)
    );

    // Next-state and capture logic for the read-modify-write sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    addr_d = req_word_s;
                    lane_d = req_lane_s;
                    byte_d = sb_data[7:0];
                    if (hit_s) begin
                        wdata_d = merged_s;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_rvalid) begin
                    wdata_d = merged_s;
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (mem_wack) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        ready_d = (state_d == ST_IDLE) | (state_d == ST_DONE);
        done_d  = (state_d == ST_DONE);
        rd_en_d = (state_d == ST_RD);
        we_d    = (state_d == ST_WR);
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            lane_q  <= 2'b00;
            byte_q  <= 8'h00;
            wdata_q <= 32'h0000_0000;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            we_q    <= we_d;
        end
    end

    assign sb_ready  = ready_q;
    assign sb_done   = done_q;
    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

endmodule
